// File: rtl/spgd_adc_capture_if.sv
// ADC capture handshake bundle: sequencer request level, the ADC sample stream,
// and the completed-capture results coming back.
interface spgd_adc_capture_if #(
    parameter int ADC_WIDTH    = 14,
    parameter int LOG2_SAMPLES = 10
);
    logic                                    ADC_EN;
    logic signed [ADC_WIDTH-1:0]             ADC_DATA;
    logic                                    ADC_DONE;
    logic signed [ADC_WIDTH+LOG2_SAMPLES-1:0] ADC_SUM;
    logic signed [ADC_WIDTH-1:0]             ADC_AVG;
    logic                                    ADC_OVR;
    logic                                    BUSY;

    // Sequencer/ADC side: drives the request and samples, reads results.
    modport master (
        output ADC_EN, ADC_DATA,
        input  ADC_DONE, ADC_SUM, ADC_AVG, ADC_OVR, BUSY
    );

    // Capture block side.
    modport slave (
        input  ADC_EN, ADC_DATA,
        output ADC_DONE, ADC_SUM, ADC_AVG, ADC_OVR, BUSY
    );
endinterface

// File: rtl/spgd_adc_capture.sv
// SPGD ADC capture: on an ADC_EN request, skip a settling window, sum
// 2^LOG2_SAMPLES signed samples, publish sum/average/rail flag and hold
// ADC_DONE until the request is withdrawn.
module spgd_adc_capture #(
    parameter int ADC_WIDTH     = 14,
    parameter int LOG2_SAMPLES  = 10,
    parameter int SETTLE_CYCLES = 2,
    parameter int SETTLE_WIDTH  = 8
) (
    input logic               ADC_CLK,
    input logic               RST,
    spgd_adc_capture_if.slave adc
);
    localparam int ACC_W = ADC_WIDTH + LOG2_SAMPLES;

    // Sample counter runs 0..N-1 and terminal-compares, so it never needs a wrap bit.
    localparam logic [LOG2_SAMPLES-1:0] SAMP_LAST = '1;
    // Unused when there is no settling window (SETTLE is then skipped).
    localparam logic [SETTLE_WIDTH-1:0] SETTLE_LAST =
        (SETTLE_CYCLES == 0) ? '0 : SETTLE_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic signed [ADC_WIDTH-1:0] CODE_MAX = {1'b0, {(ADC_WIDTH-1){1'b1}}};
    localparam logic signed [ADC_WIDTH-1:0] CODE_MIN = {1'b1, {(ADC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACCUM  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [SETTLE_WIDTH-1:0]    settle_cnt_q, settle_cnt_d;
    logic [LOG2_SAMPLES-1:0]    samp_cnt_q, samp_cnt_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic                       ovr_trk_q, ovr_trk_d;
    logic signed [ACC_W-1:0]    sum_q, sum_d;
    logic signed [ADC_WIDTH-1:0] avg_q, avg_d;
    logic                       ovr_q, ovr_d;
    logic                       done_q, done_d;
    logic                       busy_q, busy_d;

    logic signed [ACC_W-1:0]    sample_ext;
    logic signed [ACC_W-1:0]    acc_add;
    logic                       is_rail;

    // Sign-extended sample, running sum including it, and rail-code detect.
    assign sample_ext = {{LOG2_SAMPLES{adc.ADC_DATA[ADC_WIDTH-1]}}, adc.ADC_DATA};
    assign acc_add    = acc_q + sample_ext;
    assign is_rail    = (adc.ADC_DATA == CODE_MAX) || (adc.ADC_DATA == CODE_MIN);

    // Next-state and datapath updates; everything holds unless a state says otherwise.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        samp_cnt_d   = samp_cnt_q;
        acc_d        = acc_q;
        ovr_trk_d    = ovr_trk_q;
        sum_d        = sum_q;
        avg_d        = avg_q;
        ovr_d        = ovr_q;
        done_d       = done_q;

        case (state_q)
            ST_IDLE: begin
                done_d = 1'b0;
                if (adc.ADC_EN) begin
                    settle_cnt_d = '0;
                    samp_cnt_d   = '0;
                    acc_d        = '0;
                    ovr_trk_d    = 1'b0;
                    state_d      = (SETTLE_CYCLES == 0) ? ST_ACCUM : ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (!adc.ADC_EN) begin
                    state_d = ST_IDLE;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_d = ST_ACCUM;
                    end
                end
            end

            ST_ACCUM: begin
                if (!adc.ADC_EN) begin
                    // Abort: previous results stay published.
                    state_d = ST_IDLE;
                end else begin
                    acc_d      = acc_add;
                    ovr_trk_d  = ovr_trk_q | is_rail;
                    samp_cnt_d = samp_cnt_q + 1'b1;
                    if (samp_cnt_q == SAMP_LAST) begin
                        state_d = ST_DONE;
                        sum_d   = acc_add;
                        // Dropping the low LOG2_SAMPLES bits of a two's-complement
                        // sum is an arithmetic shift, i.e. floor toward -inf.
                        avg_d   = acc_add[ACC_W-1:LOG2_SAMPLES];
                        ovr_d   = ovr_trk_q | is_rail;
                        done_d  = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                // Holding ADC_EN high here never restarts; it must drop first.
                if (!adc.ADC_EN) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                done_d  = 1'b0;
            end
        endcase

        busy_d = (state_d == ST_SETTLE) || (state_d == ST_ACCUM);
    end

    // State and result registers, cleared asynchronously by RST.
    always_ff @(posedge ADC_CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            samp_cnt_q   <= '0;
            acc_q        <= '0;
            ovr_trk_q    <= 1'b0;
            sum_q        <= '0;
            avg_q        <= '0;
            ovr_q        <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            samp_cnt_q   <= samp_cnt_d;
            acc_q        <= acc_d;
            ovr_trk_q    <= ovr_trk_d;
            sum_q        <= sum_d;
            avg_q        <= avg_d;
            ovr_q        <= ovr_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign adc.ADC_DONE = done_q;
    assign adc.ADC_SUM  = sum_q;
    assign adc.ADC_AVG  = avg_q;
    assign adc.ADC_OVR  = ovr_q;
    assign adc.BUSY     = busy_q;
endmodule
